// File: rtl/ysyx_24110006_core_seq.sv
// Multi-cycle control sequencer for the single-issue core.
// Walks each instruction through FETCH/DECODE/EXEC/(MEM)/WB with one-hot
// stage strobes. It halts on a retired ebreak and traps bus errors or hung
// FETCH/MEM transactions with a watchdog. It also keeps mcycle/minstret.
module ysyx_24110006_core_seq #(
   parameter int TIMEOUT = 1024,   // cycles allowed in FETCH/MEM without done (>= 2)
   parameter int CNT_W   = 64      // width of the performance counters
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_ifu_done,
   input  logic             i_ifu_err,
   input  logic             i_mem_op,
   input  logic             i_ebreak,
   input  logic             i_lsu_done,
   input  logic             i_lsu_err,
   output logic             o_fetch_start,
   output logic             o_idu_valid,
   output logic             o_exu_valid,
   output logic             o_lsu_start,
   output logic             o_commit,
   output logic             o_halted,
   output logic             o_error,
   output logic [1:0]       o_err_code,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_mcycle,
   output logic [CNT_W-1:0] o_minstret
);

   localparam int              WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_IFU     = 2'd1;
   localparam logic [1:0] ERR_LSU     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_err_code;
   logic [1:0]       w_next_err_code;
   logic [WD_W-1:0]  r_wdog;
   logic             r_ebreak;
   logic [CNT_W-1:0] r_mcycle;
   logic [CNT_W-1:0] r_minstret;

   logic             w_in_wait;
   logic             w_wd_expired;
   logic             w_first_cycle;
   logic             w_running;

   // The watchdog is zero only in the entry cycle of a wait state. It is
   // cleared whenever FETCH/MEM is left, and it never wraps because the
   // FSM leaves at WD_LAST.
   assign w_in_wait     = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_wd_expired  = (r_wdog == WD_LAST);
   assign w_first_cycle = (r_wdog == '0);
   assign w_running     = (r_state != S_HALT) && (r_state != S_ERR);

   // Next-state and trap-code selection; an error beats done, done beats timeout
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_next_state    = r_state;
      w_next_err_code = r_err_code;
      case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH: begin
            if (i_ifu_done) begin
               if (i_ifu_err) begin
                  w_next_state    = S_ERR;
                  w_next_err_code = ERR_IFU;
               end else begin
                  w_next_state = S_DECODE;
               end
            end else if (w_wd_expired) begin
               w_next_state    = S_ERR;
               w_next_err_code = ERR_TIMEOUT;
            end
         end
         S_DECODE: w_next_state = S_EXEC;
         // ebreak never goes to memory, even if it also decodes as mem_op
         S_EXEC:   w_next_state = (i_mem_op && !i_ebreak) ? S_MEM : S_WB;
         S_MEM: begin
            if (i_lsu_done) begin
               if (i_lsu_err) begin
                  w_next_state    = S_ERR;
                  w_next_err_code = ERR_LSU;
               end else begin
                  w_next_state = S_WB;
               end
            end else if (w_wd_expired) begin
               w_next_state    = S_ERR;
               w_next_err_code = ERR_TIMEOUT;
            end
         end
         S_WB:     w_next_state = r_ebreak ? S_HALT : S_FETCH;
         S_HALT:   w_next_state = S_HALT;
         S_ERR:    w_next_state = S_ERR;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // State, trap code, ebreak latch and watchdog registers
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      if (reset) begin
         r_state    <= S_IDLE;
         r_err_code <= ERR_NONE;
         r_ebreak   <= 1'b0;
         r_wdog     <= '0;
      end else begin
         r_state    <= w_next_state;
         r_err_code <= w_next_err_code;
         if (r_state == S_EXEC) begin
            r_ebreak <= i_ebreak;
         end
         if (w_in_wait && (w_next_state == r_state)) begin
            r_wdog <= r_wdog + WD_W'(1);
         end else begin
            r_wdog <= '0;
         end
      end
   end

   // Performance counters: mcycle freezes once terminal, minstret counts WB cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (w_running) begin
            r_mcycle <= r_mcycle + CNT_W'(1);
         end
         if (r_state == S_WB) begin
            r_minstret <= r_minstret + CNT_W'(1);
         end
      end
   end

   assign o_fetch_start = (r_state == S_FETCH) && w_first_cycle;
   assign o_idu_valid   = (r_state == S_DECODE);
   assign o_exu_valid   = (r_state == S_EXEC);
   assign o_lsu_start   = (r_state == S_MEM) && w_first_cycle;
   assign o_commit      = (r_state == S_WB);
   assign o_halted      = (r_state == S_HALT);
   assign o_error       = (r_state == S_ERR);
   assign o_err_code    = r_err_code;
   assign o_state       = r_state;
   assign o_mcycle      = r_mcycle;
   assign o_minstret    = r_minstret;

endmodule

// File: tb/tb_ysyx_24110006_core_seq.sv
// Testbench for ysyx_24110006_core_seq.
// Each instruction is described as a transaction (fetch delay, mem op,
// ebreak, LSU delay, error flags). It is expanded into the per-cycle
// timeline that the sequencing rules imply, then replayed against the DUT
// one cycle at a time.
module tb_ysyx_24110006_core_seq;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALT   = 3'd6;
   localparam logic [2:0] ST_ERR    = 3'd7;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             i_ifu_done = 1'b0;
   logic             i_ifu_err = 1'b0;
   logic             i_mem_op = 1'b0;
   logic             i_ebreak = 1'b0;
   logic             i_lsu_done = 1'b0;
   logic             i_lsu_err = 1'b0;
   logic             o_fetch_start;
   logic             o_idu_valid;
   logic             o_exu_valid;
   logic             o_lsu_start;
   logic             o_commit;
   logic             o_halted;
   logic             o_error;
   logic [1:0]       o_err_code;
   logic [2:0]       o_state;
   logic [CNT_W-1:0] o_mcycle;
   logic [CNT_W-1:0] o_minstret;

   int               n_checks = 0;
   int               n_errors = 0;
   int               cyc_idx  = 0;
   logic [CNT_W-1:0] m_cyc;
   logic [CNT_W-1:0] m_ret;

   // One expected cycle: the visible state, the stage strobes
   // {fetch_start, idu, exu, lsu_start, commit}, the trap code, and the
   // inputs to drive during that cycle.
   typedef struct {
      logic [2:0] st;
      logic [4:0] stage;
      logic [1:0] code;
      logic       ifu_done;
      logic       ifu_err;
      logic       lsu_done;
      logic       lsu_err;
      logic       mem_op;
      logic       ebreak;
   } cyc_t;

   // Delays count cycles after entry into the wait state (0 = entry cycle).
   typedef struct {
      int f_dly;
      bit f_err;
      bit mem;
      bit ebrk;
      int l_dly;
      bit l_err;
   } instr_t;

   cyc_t exp_q[$];

   ysyx_24110006_core_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .i_ifu_done    (i_ifu_done),
      .i_ifu_err     (i_ifu_err),
      .i_mem_op      (i_mem_op),
      .i_ebreak      (i_ebreak),
      .i_lsu_done    (i_lsu_done),
      .i_lsu_err     (i_lsu_err),
      .o_fetch_start (o_fetch_start),
      .o_idu_valid   (o_idu_valid),
      .o_exu_valid   (o_exu_valid),
      .o_lsu_start   (o_lsu_start),
      .o_commit      (o_commit),
      .o_halted      (o_halted),
      .o_error       (o_error),
      .o_err_code    (o_err_code),
      .o_state       (o_state),
      .o_mcycle      (o_mcycle),
      .o_minstret    (o_minstret)
   );

   always #5 clock = ~clock;

   function automatic logic rnd(input int one_in);
      return ($urandom_range(one_in - 1, 0) == 0);
   endfunction

   function automatic instr_t mk(input int f_dly, input bit f_err, input bit mem,
                                 input bit ebrk, input int l_dly, input bit l_err);
      instr_t t;
      t.f_dly = f_dly; t.f_err = f_err; t.mem = mem;
      t.ebrk  = ebrk;  t.l_dly = l_dly; t.l_err = l_err;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      t.f_dly = rnd(8) ? $urandom_range(TIMEOUT + 1, 0) : $urandom_range(3, 0);
      t.f_err = rnd(40);
      t.mem   = rnd(2);
      t.ebrk  = rnd(40);
      t.l_dly = rnd(8) ? $urandom_range(TIMEOUT + 1, 0) : $urandom_range(5, 0);
      t.l_err = rnd(40);
      return t;
   endfunction

   task automatic push(input logic [2:0] st, input logic [4:0] stage, input logic [1:0] code,
                       input logic idn, input logic ie, input logic ldn, input logic le,
                       input logic mo, input logic eb);
      cyc_t c;
      c.st = st; c.stage = stage; c.code = code;
      c.ifu_done = idn; c.ifu_err = ie; c.lsu_done = ldn; c.lsu_err = le;
      c.mem_op = mo; c.ebreak = eb;
      exp_q.push_back(c);
   endtask

   // A cycle in which done pulses must be ignored, so it is sprinkled with noise.
   task automatic push_noise(input logic [2:0] st, input logic [4:0] stage, input logic [1:0] code,
                             input logic mo, input logic eb);
      push(st, stage, code, rnd(3), rnd(2), rnd(3), rnd(2), mo, eb);
   endtask

   task automatic gen_term(input logic [2:0] st, input logic [1:0] code);
      repeat (6) push_noise(st, 5'b00000, code, rnd(2), rnd(2));
   endtask

   // Expand one instruction into its expected cycle timeline.
   task automatic gen_instr(input instr_t t, output bit term);
      int n;
      term = 1'b0;
      // A wait phase lasts until done, or TIMEOUT cycles at most.
      n = (t.f_dly < TIMEOUT) ? t.f_dly + 1 : TIMEOUT;
      for (int k = 0; k < n; k++) begin
         logic d;
         d = (k == t.f_dly);
         push(ST_FETCH, (k == 0) ? 5'b10000 : 5'b00000, 2'd0,
              d, d ? logic'(t.f_err) : rnd(2), 1'b0, rnd(2), rnd(2), rnd(2));
      end
      if (t.f_dly >= TIMEOUT) begin gen_term(ST_ERR, 2'd3); term = 1'b1; return; end
      if (t.f_err)            begin gen_term(ST_ERR, 2'd1); term = 1'b1; return; end
      push_noise(ST_DECODE, 5'b01000, 2'd0, rnd(2), rnd(2));
      push_noise(ST_EXEC, 5'b00100, 2'd0, t.mem, t.ebrk);
      if (t.mem && !t.ebrk) begin
         n = (t.l_dly < TIMEOUT) ? t.l_dly + 1 : TIMEOUT;
         for (int k = 0; k < n; k++) begin
            logic d;
            d = (k == t.l_dly);
            push(ST_MEM, (k == 0) ? 5'b00010 : 5'b00000, 2'd0,
                 1'b0, rnd(2), d, d ? logic'(t.l_err) : rnd(2), rnd(2), rnd(2));
         end
         if (t.l_dly >= TIMEOUT) begin gen_term(ST_ERR, 2'd3); term = 1'b1; return; end
         if (t.l_err)            begin gen_term(ST_ERR, 2'd2); term = 1'b1; return; end
      end
      push_noise(ST_WB, 5'b00001, 2'd0, rnd(2), rnd(2));
      if (t.ebrk) begin gen_term(ST_HALT, 2'd0); term = 1'b1; end
   endtask

   // Called at a negedge: holds reset for n edges, then releases it and
   // queues the IDLE cycle that must follow.
   task automatic do_reset(input int n);
      reset = 1'b1;
      i_ifu_done = 1'b0; i_ifu_err = 1'b0; i_lsu_done = 1'b0;
      i_lsu_err = 1'b0; i_mem_op = 1'b0; i_ebreak = 1'b0;
      repeat (n) @(negedge clock);
      reset = 1'b0;
      m_cyc = '0;
      m_ret = '0;
      exp_q.delete();
      push_noise(ST_IDLE, 5'b00000, 2'd0, rnd(2), rnd(2));
   endtask

   // Replay the expected timeline: drive inputs and compare outputs at each negedge.
   task automatic execute_and_compare();
      while (exp_q.size() > 0) begin
         cyc_t c;
         c = exp_q.pop_front();
         i_ifu_done = c.ifu_done; i_ifu_err = c.ifu_err;
         i_lsu_done = c.lsu_done; i_lsu_err = c.lsu_err;
         i_mem_op   = c.mem_op;   i_ebreak  = c.ebreak;
         n_checks++;
         if (o_state !== c.st) begin
            n_errors++;
            $display("FAIL state @%0d: got %0d, expected %0d", cyc_idx, o_state, c.st);
         end
         n_checks++;
         if ({o_fetch_start, o_idu_valid, o_exu_valid, o_lsu_start, o_commit} !== c.stage) begin
            n_errors++;
            $display("FAIL stage_strobes @%0d: got %b, expected %b", cyc_idx,
                     {o_fetch_start, o_idu_valid, o_exu_valid, o_lsu_start, o_commit}, c.stage);
         end
         n_checks++;
         if (o_mcycle !== m_cyc) begin
            n_errors++;
            $display("FAIL mcycle @%0d: got %0d, expected %0d", cyc_idx, o_mcycle, m_cyc);
         end
         n_checks++;
         if (o_minstret !== m_ret) begin
            n_errors++;
            $display("FAIL minstret @%0d: got %0d, expected %0d", cyc_idx, o_minstret, m_ret);
         end
         n_checks++;
         if ({o_halted, o_error, o_err_code} !== {c.st == ST_HALT, c.st == ST_ERR, c.code}) begin
            n_errors++;
            $display("FAIL halt_err_code @%0d: got %b, expected %b", cyc_idx,
                     {o_halted, o_error, o_err_code}, {c.st == ST_HALT, c.st == ST_ERR, c.code});
         end
         if (c.st != ST_HALT && c.st != ST_ERR) m_cyc = m_cyc + CNT_W'(1);
         if (c.st == ST_WB) m_ret = m_ret + CNT_W'(1);
         cyc_idx++;
         @(negedge clock);
      end
      i_ifu_done = 1'b0; i_lsu_done = 1'b0;
   endtask

   // Reset held 3 cycles, no IFU response ever: fixed-value expectations.
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      n_checks++;
      if (o_state !== 3'd0 || o_mcycle !== '0 || o_minstret !== '0 ||
          {o_fetch_start, o_idu_valid, o_exu_valid, o_lsu_start, o_commit,
           o_halted, o_error, o_err_code} !== 9'd0) begin
         n_errors++;
         $display("FAIL reset_cycle0: state=%0d mcycle=%0d minstret=%0d, expected all zero",
                  o_state, o_mcycle, o_minstret);
      end
      @(negedge clock);
      n_checks++;
      if (o_state !== 3'd1 || o_fetch_start !== 1'b1 || o_mcycle !== 8'd1) begin
         n_errors++;
         $display("FAIL reset_cycle1: state=%0d fetch_start=%b mcycle=%0d, expected 1/1/1",
                  o_state, o_fetch_start, o_mcycle);
      end
      @(negedge clock);
      n_checks++;
      if (o_state !== 3'd1 || o_fetch_start !== 1'b0 || o_mcycle !== 8'd2) begin
         n_errors++;
         $display("FAIL reset_cycle2: state=%0d fetch_start=%b mcycle=%0d, expected 1/0/2",
                  o_state, o_fetch_start, o_mcycle);
      end
      // FETCH entered at cycle 1, so the watchdog traps at cycle 1+TIMEOUT
      repeat (TIMEOUT - 1) @(negedge clock);
      n_checks++;
      if (o_state !== 3'd7 || o_err_code !== 2'd3 || o_mcycle !== 8'(TIMEOUT + 1)) begin
         n_errors++;
         $display("FAIL fetch_timeout: state=%0d code=%0d mcycle=%0d, expected 7/3/%0d",
                  o_state, o_err_code, o_mcycle, TIMEOUT + 1);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (o_mcycle !== 8'(TIMEOUT + 1)) begin
         n_errors++;
         $display("FAIL mcycle_frozen_err: got %0d, expected %0d", o_mcycle, TIMEOUT + 1);
      end
   endtask

   task automatic test_non_mem();
      bit term;
      do_reset(2);
      gen_instr(mk(2, 0, 0, 0, 0, 0), term);
      gen_instr(mk(0, 0, 0, 0, 0, 0), term);
      execute_and_compare();
      n_checks++;
      if (o_minstret !== 8'd2 || o_state !== 3'd1 || o_fetch_start !== 1'b1) begin
         n_errors++;
         $display("FAIL non_mem_after: minstret=%0d state=%0d fetch_start=%b, expected 2/1/1",
                  o_minstret, o_state, o_fetch_start);
      end
   endtask

   task automatic test_back_to_back_loads();
      bit term;
      do_reset(1);
      for (int i = 0; i < 20; i++) gen_instr(mk($urandom_range(2, 0), 0, 1, 0, 4, 0), term);
      execute_and_compare();
      n_checks++;
      if (o_minstret !== 8'd20) begin
         n_errors++;
         $display("FAIL loads_minstret: got %0d, expected 20", o_minstret);
      end
   endtask

   task automatic test_ebreak();
      bit term;
      do_reset(1);
      gen_instr(mk(1, 0, 0, 0, 0, 0), term);
      gen_instr(mk(0, 0, 1, 0, 1, 0), term);
      gen_instr(mk(0, 0, 1, 1, 0, 0), term);   // ebreak that also decodes as mem_op
      execute_and_compare();
      n_checks++;
      if (o_state !== 3'd6 || o_halted !== 1'b1 || o_minstret !== 8'd3) begin
         n_errors++;
         $display("FAIL ebreak_halt: state=%0d halted=%b minstret=%0d, expected 6/1/3",
                  o_state, o_halted, o_minstret);
      end
   endtask

   task automatic test_timeout();
      bit term;
      do_reset(1);
      gen_instr(mk(0, 0, 1, 0, TIMEOUT, 0), term);       // no LSU done in the window
      execute_and_compare();
      n_checks++;
      if (o_error !== 1'b1 || o_err_code !== 2'd3) begin
         n_errors++;
         $display("FAIL mem_timeout: error=%b code=%0d, expected 1/3", o_error, o_err_code);
      end
      do_reset(1);
      gen_instr(mk(0, 0, 1, 0, TIMEOUT - 1, 0), term);   // done on the last allowed cycle
      gen_instr(mk(TIMEOUT - 1, 0, 0, 0, 0, 0), term);
      execute_and_compare();
      n_checks++;
      if (o_error !== 1'b0 || o_minstret !== 8'd2) begin
         n_errors++;
         $display("FAIL done_at_expiry: error=%b minstret=%0d, expected 0/2", o_error, o_minstret);
      end
   endtask

   task automatic test_bus_errors();
      bit term;
      do_reset(1);
      gen_instr(mk(1, 1, 0, 0, 0, 0), term);
      execute_and_compare();
      n_checks++;
      if (o_err_code !== 2'd1 || o_minstret !== 8'd0) begin
         n_errors++;
         $display("FAIL ifu_err: code=%0d minstret=%0d, expected 1/0", o_err_code, o_minstret);
      end
      do_reset(1);
      gen_instr(mk(0, 0, 1, 0, 2, 1), term);
      execute_and_compare();
      n_checks++;
      if (o_err_code !== 2'd2 || o_minstret !== 8'd0) begin
         n_errors++;
         $display("FAIL lsu_err: code=%0d minstret=%0d, expected 2/0", o_err_code, o_minstret);
      end
   endtask

   task automatic test_reset_mid_mem();
      bit   term;
      int   mem_seen;
      cyc_t keep[$];
      do_reset(1);
      gen_instr(mk(0, 0, 0, 0, 0, 0), term);
      gen_instr(mk(1, 0, 1, 0, TIMEOUT + 3, 0), term);
      mem_seen = 0;
      foreach (exp_q[i]) begin
         if (mem_seen < 3) begin
            keep.push_back(exp_q[i]);
            if (exp_q[i].st == ST_MEM) mem_seen++;
         end
      end
      exp_q = keep;
      execute_and_compare();
      // Reset arrives together with the LSU done: the load must not commit.
      reset = 1'b1;
      i_lsu_done = 1'b1;
      @(negedge clock);
      i_lsu_done = 1'b0;
      n_checks++;
      if (o_state !== 3'd0 || o_commit !== 1'b0 || o_mcycle !== '0 || o_minstret !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_mem: state=%0d commit=%b mcycle=%0d minstret=%0d, expected 0/0/0/0",
                  o_state, o_commit, o_mcycle, o_minstret);
      end
      do_reset(1);
      gen_instr(mk(0, 0, 0, 0, 0, 0), term);
      execute_and_compare();
   endtask

   task automatic test_random();
      bit term;
      for (int p = 0; p < 4; p++) begin
         do_reset($urandom_range(3, 1));
         for (int i = 0; i < 30; i++) begin
            gen_instr(rand_instr(), term);
            if (term) break;
         end
         execute_and_compare();
      end
   endtask

   initial begin
      m_cyc = '0;
      m_ret = '0;
      test_reset();
      test_non_mem();
      test_back_to_back_loads();
      test_ebreak();
      test_timeout();
      test_bus_errors();
      test_reset_mid_mem();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
